// File: rtl/fp_add_reducer.sv
// fp_add_reducer: sums framed float vectors by pairing LIFO partial sums through an external adder.
module fp_add_reducer #(
    parameter int DATA_W  = 32,
    parameter int POOL_D  = 8,
    parameter int MAX_OUT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              add_start,
    output logic [DATA_W-1:0] add_op_a,
    output logic [DATA_W-1:0] add_op_b,
    input  logic              add_done,
    input  logic [DATA_W-1:0] add_res,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [DATA_W-1:0] sum
);
    localparam int CW = $clog2(POOL_D + 1);
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int IW = $clog2(POOL_D);
    localparam int SW = (CW > OW ? CW : OW) + 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;

    state_t            state;
    logic [CW-1:0]     cnt, cnt_pop, cnt_res, cnt_nxt;
    logic [OW-1:0]     out_cnt;
    logic [DATA_W-1:0] entry [POOL_D];
    logic              issue, done_ok, accept;
    logic [IW-1:0]     idx_a, idx_b, idx_res, idx_in;

    // Occupancy counts in-flight adds, so a returning result always has a free slot.
    assign in_ready = (state == ACCUM) && (SW'(cnt) + SW'(out_cnt) <= SW'(POOL_D - 1));
    assign issue    = (state != OUT) && (cnt >= CW'(2)) && (out_cnt < OW'(MAX_OUT));
    assign done_ok  = add_done && (out_cnt != '0);
    assign accept   = in_valid && in_ready;
    assign cnt_pop  = issue ? cnt - CW'(2) : cnt;
    assign cnt_res  = cnt_pop + CW'(done_ok);
    assign cnt_nxt  = cnt_res + CW'(accept);
    assign idx_a    = IW'(cnt - CW'(1));
    assign idx_b    = IW'(cnt - CW'(2));
    assign idx_res  = IW'(cnt_pop);
    assign idx_in   = IW'(cnt_res);

    // Pool writes land above the popped pair: adder result first, then the new element.
    always_ff @(posedge clk) begin
        if (done_ok) entry[idx_res] <= add_res;
        if (accept) entry[idx_in] <= in_data;
    end

    // Control FSM with registered adder issue and registered sum hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            cnt       <= '0;
            out_cnt   <= '0;
            add_start <= 1'b0;
            add_op_a  <= '0;
            add_op_b  <= '0;
            sum_valid <= 1'b0;
            sum       <= '0;
        end else begin
            add_start <= issue;
            if (issue) begin
                add_op_a <= entry[idx_a];
                add_op_b <= entry[idx_b];
            end
            out_cnt <= out_cnt + OW'(issue) - OW'(done_ok);
            case (state)
                ACCUM: begin
                    cnt <= cnt_nxt;
                    if (accept && in_last) state <= DRAIN;
                end
                DRAIN: begin
                    cnt <= cnt_nxt;
                    if (cnt == CW'(1) && out_cnt == '0) begin
                        state     <= OUT;
                        sum       <= entry[0];
                        sum_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (sum_ready) begin
                        state     <= ACCUM;
                        cnt       <= '0;
                        sum_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
